// File: rtl/tweezer_pkg.sv
// Shared types for the optical tweezer trapping loop sequencer.
// State codes, CLEAR/LOST timing and PI control decode.
package tweezer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    CLEAR   = 3'd2,
    RUN     = 3'd3,
    FREEZE  = 3'd4
  } state_t;

  localparam int CLEAR_CYCLES = 4;
  localparam int LOST_CYCLES  = 4;

  typedef struct packed {
    logic rst;
    logic en;
    logic frz;
  } pi_ctrl_t;

  function automatic pi_ctrl_t pi_decode(input state_t s);
    pi_ctrl_t p;
    p = '0;
    case (s)
      IDLE, CLEAR: p.rst = 1'b1;
      RUN:         p.en  = 1'b1;
      FREEZE: begin
        p.en  = 1'b1;
        p.frz = 1'b1;
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/presence_debouncer.sv
// Consecutive-hit counter with saturation and target match.
// match fires when the count including this cycle equals target.
module presence_debouncer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         hit,
  input  logic [W-1:0] target,
  output logic         match
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
  assign match   = hit && !clear && (cnt_inc == target);

  always_ff @(posedge clk) begin
    if (reset || clear || !hit)
      cnt_q <= '0;
    else
      cnt_q <= cnt_inc;
  end

endmodule

// File: rtl/tweezer_loop_sequencer.sv
// Closes the PI trapping loop once a bead is present and settled,
// with saturation freeze hysteresis and bead-loss recovery.
module tweezer_loop_sequencer
  import tweezer_pkg::*;
#(
  parameter int dataBitSize = 16,
  parameter int cntBitSize  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loop_enable,
  input  logic [dataBitSize-1:0] SUM,
  input  logic [dataBitSize-1:0] sum_threshold,
  input  logic [cntBitSize-1:0]  settle_cycles,
  input  logic [dataBitSize-1:0] ctrl_out,
  input  logic                   ctrl_out_valid,
  input  logic [dataBitSize-1:0] sat_limit,
  output logic                   PI_reset,
  output logic                   PI_enable,
  output logic                   PI_freeze,
  output logic [2:0]             state,
  output logic                   bead_lost,
  output logic [7:0]             lost_count
);

  localparam int D = dataBitSize;
  localparam int C = cntBitSize;

  localparam logic [D-1:0] MOST_NEG = {1'b1, {(D-1){1'b0}}};
  localparam logic [D-1:0] MAX_POS  = {1'b0, {(D-1){1'b1}}};
  localparam logic [C-1:0] C_ONE    = {{(C-1){1'b0}}, 1'b1};
  localparam logic [C-1:0] LOST_TGT = C'(LOST_CYCLES);
  localparam logic [2:0]   CLR_LAST = 3'(CLEAR_CYCLES - 1);

  state_t     st_q;
  state_t     st_d;
  pi_ctrl_t   pi_q;
  logic [2:0] clr_cnt;
  logic       lost_evt;
  logic       present;
  logic       acq_match;
  logic       loss_match;
  logic       sat_hi;
  logic       sat_lo;
  logic       in_loop;
  logic [D-1:0] mag;
  logic [C-1:0] settle_tgt;

  assign present    = $signed(SUM) > $signed(sum_threshold);
  assign settle_tgt = (settle_cycles == '0) ? C_ONE : settle_cycles;
  assign in_loop    = (st_q == RUN) || (st_q == FREEZE);

  always_comb begin
    mag = ctrl_out;
    if (ctrl_out == MOST_NEG)
      mag = MAX_POS;
    else if (ctrl_out[D-1])
      mag = -ctrl_out;
  end

  // FREEZE releases only below half the limit
  assign sat_hi = ctrl_out_valid &&
                  ($signed(mag) >= $signed(sat_limit));
  assign sat_lo = ctrl_out_valid &&
                  ($signed(mag) < ($signed(sat_limit) >>> 1));

  presence_debouncer #(.W(C)) u_acq (
    .clk    (clk),
    .reset  (reset),
    .clear  (st_q != ACQUIRE),
    .hit    (present),
    .target (settle_tgt),
    .match  (acq_match)
  );

  presence_debouncer #(.W(C)) u_loss (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_loop),
    .hit    (!present),
    .target (LOST_TGT),
    .match  (loss_match)
  );

  always_comb begin
    st_d     = st_q;
    lost_evt = 1'b0;
    if (!loop_enable) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE:    st_d = ACQUIRE;
        ACQUIRE: if (acq_match) st_d = CLEAR;
        CLEAR:   if (clr_cnt == CLR_LAST) st_d = RUN;
        RUN: begin
          if (loss_match) begin
            st_d     = ACQUIRE;
            lost_evt = 1'b1;
          end else if (sat_hi) begin
            st_d = FREEZE;
          end
        end
        FREEZE: begin
          if (loss_match) begin
            st_d     = ACQUIRE;
            lost_evt = 1'b1;
          end else if (sat_lo) begin
            st_d = RUN;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= IDLE;
      pi_q       <= pi_decode(IDLE);
      clr_cnt    <= '0;
      bead_lost  <= 1'b0;
      lost_count <= '0;
    end else begin
      st_q      <= st_d;
      pi_q      <= pi_decode(st_d);
      bead_lost <= lost_evt;
      clr_cnt   <= (st_q == CLEAR) ? clr_cnt + 3'd1 : 3'd0;
      if (lost_evt && lost_count != 8'hFF)
        lost_count <= lost_count + 8'd1;
    end
  end

  assign state     = st_q;
  assign PI_reset  = pi_q.rst;
  assign PI_enable = pi_q.en;
  assign PI_freeze = pi_q.frz;

endmodule

// File: tb/tb_tweezer_loop_sequencer.sv
// Directed bench for tweezer_loop_sequencer: vector table plus
// hand sequences for debounce restart, abort, loss and saturation.
module tb_tweezer_loop_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        loop_enable;
  logic [15:0] SUM;
  logic [15:0] sum_threshold;
  logic [15:0] settle_cycles;
  logic [15:0] ctrl_out;
  logic        ctrl_out_valid;
  logic [15:0] sat_limit;
  logic        PI_reset;
  logic        PI_enable;
  logic        PI_freeze;
  logic [2:0]  state;
  logic        bead_lost;
  logic [7:0]  lost_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tweezer_loop_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .loop_enable    (loop_enable),
    .SUM            (SUM),
    .sum_threshold  (sum_threshold),
    .settle_cycles  (settle_cycles),
    .ctrl_out       (ctrl_out),
    .ctrl_out_valid (ctrl_out_valid),
    .sat_limit      (sat_limit),
    .PI_reset       (PI_reset),
    .PI_enable      (PI_enable),
    .PI_freeze      (PI_freeze),
    .state          (state),
    .bead_lost      (bead_lost),
    .lost_count     (lost_count)
  );

  typedef struct {
    logic        le;
    logic [15:0] sum;
    logic [15:0] ctrl;
    logic        vld;
    logic [15:0] sat;
    logic [2:0]  st;
    logic [2:0]  pi;
    logic        bl;
    logic [7:0]  lc;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(
    input logic le, input int sum, input int ctrl,
    input logic vld, input int sat, input int st,
    input logic [2:0] pi, input logic bl, input int lc);
    vec_t v;
    v.le   = le;
    v.sum  = 16'(sum);
    v.ctrl = 16'(ctrl);
    v.vld  = vld;
    v.sat  = 16'(sat);
    v.st   = 3'(st);
    v.pi   = pi;
    v.bl   = bl;
    v.lc   = 8'(lc);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got,
                     input int exp);
    n_checks++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic chk_all(input string name, input int st,
                         input logic [2:0] pi, input logic bl,
                         input int lc);
    chk({name, ".state"}, int'(state), st);
    chk({name, ".pi"}, int'({PI_reset, PI_enable, PI_freeze}),
        int'(pi));
    chk({name, ".bead_lost"}, int'(bead_lost), int'(bl));
    chk({name, ".lost_count"}, int'(lost_count), lc);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    loop_enable    = 1'b0;
    SUM            = 16'd2000;
    sum_threshold  = 16'd1000;
    settle_cycles  = 16'd5;
    ctrl_out       = '0;
    ctrl_out_valid = 1'b0;
    sat_limit      = 16'd16000;
    step();
    step();
    chk_all("reset", 0, 3'b100, 1'b0, 0);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 2000, 0, 0, 16000, 1, 3'b000, 0, 0);
    tbl[1]  = mk(1, 2000, 0, 0, 16000, 1, 3'b000, 0, 0);
    tbl[2]  = mk(1, 2000, 0, 0, 16000, 1, 3'b000, 0, 0);
    tbl[3]  = mk(1, 2000, 0, 0, 16000, 1, 3'b000, 0, 0);
    tbl[4]  = mk(1, 2000, 0, 0, 16000, 1, 3'b000, 0, 0);
    tbl[5]  = mk(1, 2000, 0, 0, 16000, 2, 3'b100, 0, 0);
    tbl[6]  = mk(1, 2000, 0, 0, 16000, 2, 3'b100, 0, 0);
    tbl[7]  = mk(1, 2000, 0, 0, 16000, 2, 3'b100, 0, 0);
    tbl[8]  = mk(1, 2000, 0, 0, 16000, 2, 3'b100, 0, 0);
    tbl[9]  = mk(1, 2000, 0, 0, 16000, 3, 3'b010, 0, 0);
    tbl[10] = mk(1, 2000, -16000, 1, 16000, 4, 3'b011, 0, 0);
    tbl[11] = mk(1, 2000, 9000, 1, 16000, 4, 3'b011, 0, 0);
    tbl[12] = mk(1, 2000, 7999, 0, 16000, 4, 3'b011, 0, 0);
    tbl[13] = mk(1, 2000, 7999, 1, 16000, 3, 3'b010, 0, 0);
    tbl[14] = mk(1, 2000, 16000, 0, 16000, 3, 3'b010, 0, 0);
    tbl[15] = mk(1, 2000, 32766, 1, 32767, 3, 3'b010, 0, 0);
    tbl[16] = mk(1, 2000, -32768, 1, 32767, 4, 3'b011, 0, 0);
    tbl[17] = mk(1, 2000, 0, 1, 32767, 3, 3'b010, 0, 0);
    tbl[18] = mk(1, 0, 0, 0, 16000, 3, 3'b010, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 16000, 3, 3'b010, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 16000, 3, 3'b010, 0, 0);
    tbl[21] = mk(1, 0, 0, 0, 16000, 1, 3'b000, 1, 1);
    tbl[22] = mk(1, 2000, 0, 0, 16000, 1, 3'b000, 0, 1);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      loop_enable    = tbl[i].le;
      SUM            = tbl[i].sum;
      ctrl_out       = tbl[i].ctrl;
      ctrl_out_valid = tbl[i].vld;
      sat_limit      = tbl[i].sat;
      step();
      chk_all($sformatf("vec%0d", i), int'(tbl[i].st),
              tbl[i].pi, tbl[i].bl, int'(tbl[i].lc));
    end

    // debounce restart, then abort from CLEAR cycle 2
    do_reset();
    loop_enable = 1'b1;
    step();
    step();
    step();
    SUM = 16'd500;
    step();
    chk("restart.dip", int'(state), 1);
    SUM = 16'd2000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("restart.acq%0d", i), int'(state), 1);
    end
    step();
    chk_all("restart.clear", 2, 3'b100, 1'b0, 0);
    step();
    loop_enable = 1'b0;
    step();
    chk_all("abort", 0, 3'b100, 1'b0, 0);

    // settle 0 acts as 1; loss beats saturation
    do_reset();
    settle_cycles = '0;
    loop_enable   = 1'b1;
    step();
    chk("s0.acq", int'(state), 1);
    step();
    chk("s0.clear", int'(state), 2);
    repeat (3) step();
    chk("s0.clear4", int'(state), 2);
    step();
    chk("s0.run", int'(state), 3);
    SUM = 16'd0;
    repeat (3) step();
    chk("boundary.run", int'(state), 3);
    ctrl_out       = 16'hC180;
    ctrl_out_valid = 1'b1;
    step();
    chk_all("loss_sat", 1, 3'b000, 1'b1, 1);
    ctrl_out_valid = 1'b0;

    for (int k = 2; k <= 256; k++) begin
      SUM = 16'd2000;
      repeat (5) step();
      SUM = 16'd0;
      repeat (4) step();
      chk($sformatf("loss%0d.lc", k), int'(lost_count),
          (k > 255) ? 255 : k);
      chk($sformatf("loss%0d.bl", k), int'(bead_lost), 1);
    end
    SUM = 16'd2000;
    step();
    chk("after_loss.bl", int'(bead_lost), 0);

    // reset while running
    repeat (4) step();
    chk("pre_rst.run", int'(state), 3);
    reset = 1'b1;
    step();
    chk_all("mid_reset", 0, 3'b100, 1'b0, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
